// File: rtl/audio_pkg.sv
// Shared definitions for the I2S codec path (ADC deserializer and DAC serializer).
// Holds the default sample width, synchronizer depth and the channel-state encoding.
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH  = 24;
    localparam int AUDIO_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LR_FALLING,
        LEFT_SKIP,
        LEFT_SHIFT,
        WAIT_LR_RISING,
        RIGHT_SKIP,
        RIGHT_SHIFT
    } i2s_state_t;

endpackage

// File: rtl/i2s_edge_detect.sv
// Brings an asynchronous codec clock into the local domain and produces
// single-cycle rise/fall pulses from the stable copy and a one-cycle-delayed copy.
module i2s_edge_detect
    import audio_pkg::*;
#(
    parameter int SYNC_STAGES = AUDIO_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   delay_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            delay_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], async_in};
            delay_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~delay_reg;
    assign fall  = ~level & delay_reg;

endmodule

// File: rtl/audio_deserializer.sv
// I2S ADC receiver: captures one left and one right word per LR frame and
// presents them together with a single-cycle valid strobe.
module audio_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
    parameter int SYNC_STAGES = AUDIO_SYNC_STAGES
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic                  i_codec_bit_clock,
    input  logic                  i_codec_lr_clock,
    input  logic                  i_codec_adc_data,
    output logic [DATA_WIDTH-1:0] o_data_left,
    output logic [DATA_WIDTH-1:0] o_data_right,
    output logic                  o_data_valid,
    output logic                  o_frame_error
);

    localparam int              CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    logic bclk_level, bclk_rise, bclk_fall;
    logic lr_level, lr_rise, lr_fall;
    logic unused_edges;

    i2s_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_edge (
        .clk      (i_clock),
        .rst_n    (i_reset_n),
        .async_in (i_codec_bit_clock),
        .level    (bclk_level),
        .rise     (bclk_rise),
        .fall     (bclk_fall)
    );

    i2s_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lr_edge (
        .clk      (i_clock),
        .rst_n    (i_reset_n),
        .async_in (i_codec_lr_clock),
        .level    (lr_level),
        .rise     (lr_rise),
        .fall     (lr_fall)
    );

    assign unused_edges = bclk_level | bclk_fall | lr_level;

    // Data uses the same depth as stable BCLK so the bit is valid when bclk_rise fires.
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   data_bit;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_sync_reg <= '0;
        end else begin
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], i_codec_adc_data};
        end
    end

    assign data_bit = data_sync_reg[SYNC_STAGES-1];

    i2s_state_t            state_reg;
    logic [CW-1:0]         count_reg;
    logic [DATA_WIDTH-1:0] shift_left_reg;
    logic [DATA_WIDTH-1:0] shift_right_reg;
    logic [DATA_WIDTH-1:0] left_hold_reg;
    logic [DATA_WIDTH-1:0] data_left_reg;
    logic [DATA_WIDTH-1:0] data_right_reg;
    logic                  data_valid_reg;
    logic                  frame_error_reg;
    logic                  in_slot;

    assign in_slot = (state_reg == LEFT_SKIP)  || (state_reg == LEFT_SHIFT) ||
                     (state_reg == RIGHT_SKIP) || (state_reg == RIGHT_SHIFT);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            shift_left_reg  <= '0;
            shift_right_reg <= '0;
            left_hold_reg   <= '0;
            data_left_reg   <= '0;
            data_right_reg  <= '0;
            data_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            data_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            if (!i_enable) begin
                state_reg <= IDLE;
                count_reg <= '0;
            end else if (in_slot && (lr_rise || lr_fall)) begin
                // Early LR edge: drop the partial word; a fall can still start a new frame.
                frame_error_reg <= 1'b1;
                count_reg       <= '0;
                state_reg       <= lr_fall ? LEFT_SKIP : WAIT_LR_FALLING;
            end else begin
                case (state_reg)
                    IDLE: begin
                        count_reg <= '0;
                        state_reg <= WAIT_LR_FALLING;
                    end
                    WAIT_LR_FALLING: begin
                        if (lr_fall) state_reg <= LEFT_SKIP;
                    end
                    LEFT_SKIP: begin
                        if (bclk_rise) state_reg <= LEFT_SHIFT;
                    end
                    LEFT_SHIFT: begin
                        if (bclk_rise) begin
                            shift_left_reg <= {shift_left_reg[DATA_WIDTH-2:0], data_bit};
                            if (count_reg == LAST_BIT) begin
                                left_hold_reg <= {shift_left_reg[DATA_WIDTH-2:0], data_bit};
                                count_reg     <= '0;
                                state_reg     <= WAIT_LR_RISING;
                            end else begin
                                count_reg <= count_reg + CW'(1);
                            end
                        end
                    end
                    WAIT_LR_RISING: begin
                        if (lr_rise) state_reg <= RIGHT_SKIP;
                    end
                    RIGHT_SKIP: begin
                        if (bclk_rise) state_reg <= RIGHT_SHIFT;
                    end
                    RIGHT_SHIFT: begin
                        if (bclk_rise) begin
                            shift_right_reg <= {shift_right_reg[DATA_WIDTH-2:0], data_bit};
                            if (count_reg == LAST_BIT) begin
                                data_left_reg  <= left_hold_reg;
                                data_right_reg <= {shift_right_reg[DATA_WIDTH-2:0], data_bit};
                                data_valid_reg <= 1'b1;
                                count_reg      <= '0;
                                state_reg      <= WAIT_LR_FALLING;
                            end else begin
                                count_reg <= count_reg + CW'(1);
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign o_data_left   = data_left_reg;
    assign o_data_right  = data_right_reg;
    assign o_data_valid  = data_valid_reg;
    assign o_frame_error = frame_error_reg;

endmodule

// File: tb/tb_audio_deserializer.sv
// Bench for audio_deserializer: drives I2S frames at BCLK = clock/16 with 32-bit slots
// and checks captured words against a scoreboard of expected left/right pairs.
module tb_audio_deserializer;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          bclk;
    logic          lrclk;
    logic          adc;
    logic [DW-1:0] data_left;
    logic [DW-1:0] data_right;
    logic          data_valid;
    logic          frame_error;

    always #5 clk = ~clk;

    audio_deserializer dut (
        .i_clock           (clk),
        .i_reset_n         (reset_n),
        .i_enable          (enable),
        .i_codec_bit_clock (bclk),
        .i_codec_lr_clock  (lrclk),
        .i_codec_adc_data  (adc),
        .o_data_left       (data_left),
        .o_data_right      (data_right),
        .o_data_valid      (data_valid),
        .o_frame_error     (frame_error)
    );

    typedef struct {
        logic [DW-1:0] left_in;
        logic [DW-1:0] right_in;
        int            left_bits;
        bit            exp_valid;
        int            exp_err;
        logic [DW-1:0] exp_left;
        logic [DW-1:0] exp_right;
    } vec_t;

    vec_t          vecs [7];
    logic [47:0]   sb_q [$];
    int            tests_run    = 0;
    int            tests_failed = 0;
    int            valid_seen   = 0;
    int            err_seen     = 0;
    int            exp_valids   = 0;
    int            exp_errs     = 0;
    logic [DW-1:0] last_left    = '0;
    logic [DW-1:0] last_right   = '0;
    logic          prev_valid   = 1'b0;
    logic          prev_err     = 1'b0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    // Bench is at a falling clock edge on entry; data and LR change with BCLK low.
    task automatic drive_bit(input logic lr, input logic d);
        bclk  = 1'b0;
        lrclk = lr;
        adc   = d;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    function automatic logic slot_bit(input logic [DW-1:0] w, input int k);
        if (k >= 1 && k <= DW) return w[DW-k];
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic drive_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int left_bits);
        for (int k = 0; k < left_bits; k++) drive_bit(1'b0, slot_bit(l, k));
        for (int k = 0; k < 32; k++) drive_bit(1'b1, slot_bit(r, k));
    endtask

    task automatic expect_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        sb_q.push_back({l, r});
        exp_valids++;
        last_left  = l;
        last_right = r;
    endtask

    always @(negedge clk) begin
        logic [47:0] exp_word;
        if (reset_n) begin
            if (data_valid) begin
                valid_seen++;
                check("valid_width", {47'd0, prev_valid}, 48'd0);
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_valid: got left=%h right=%h, required no valid", data_left, data_right);
                end else begin
                    exp_word = sb_q.pop_front();
                    check("frame_data", {data_left, data_right}, exp_word);
                    $display("[TB] frame %0d: left=%h right=%h", valid_seen, data_left, data_right);
                end
            end
            if (frame_error) begin
                err_seen++;
                check("error_width", {47'd0, prev_err}, 48'd0);
                $display("[TB] frame error pulse %0d", err_seen);
            end
        end
        prev_valid = data_valid;
        prev_err   = frame_error;
    end

    initial begin
        vecs[0] = '{24'h800001, 24'h7FFFFE, 32, 1'b1, 0, 24'h800001, 24'h7FFFFE};
        vecs[1] = '{24'h000001, 24'hFFFFFF, 32, 1'b1, 0, 24'h000001, 24'hFFFFFF};
        vecs[2] = '{24'h000002, 24'hFFFFFE, 32, 1'b1, 0, 24'h000002, 24'hFFFFFE};
        vecs[3] = '{24'h000003, 24'hFFFFFD, 32, 1'b1, 0, 24'h000003, 24'hFFFFFD};
        vecs[4] = '{24'h000004, 24'hFFFFFC, 32, 1'b1, 0, 24'h000004, 24'hFFFFFC};
        vecs[5] = '{24'h654321, 24'h0FEDCB, 13, 1'b0, 1, 24'h000000, 24'h000000};
        vecs[6] = '{24'h123456, 24'hABCDEF, 32, 1'b1, 0, 24'h123456, 24'hABCDEF};

        reset_n = 1'b0;
        enable  = 1'b1;
        bclk    = 1'b0;
        lrclk   = 1'b1;
        adc     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_left",  {24'd0, data_left},   48'd0);
        check("rst_right", {24'd0, data_right},  48'd0);
        check("rst_valid", {47'd0, data_valid},  48'd0);
        check("rst_error", {47'd0, frame_error}, 48'd0);

        // Release reset in the middle of a right slot; nothing until the next full frame.
        for (int k = 0; k < 10; k++) drive_bit(1'b1, logic'($urandom_range(0, 1)));
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) drive_bit(1'b1, logic'($urandom_range(0, 1)));
        expect_frame(24'h13579B, 24'h2468AC);
        drive_frame(24'h13579B, 24'h2468AC, 32);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_valid) expect_frame(vecs[i].exp_left, vecs[i].exp_right);
            exp_errs += vecs[i].exp_err;
            drive_frame(vecs[i].left_in, vecs[i].right_in, vecs[i].left_bits);
        end

        // Enable dropped during the left data bits: frame abandoned silently.
        fork
            drive_frame(24'hDEAD01, 24'hBEEF02, 32);
            begin
                repeat (200) @(negedge clk);
                enable = 1'b0;
                repeat (100) @(negedge clk);
                enable = 1'b1;
            end
        join
        check("hold_left",  {24'd0, data_left},  {24'd0, last_left});
        check("hold_right", {24'd0, data_right}, {24'd0, last_right});
        expect_frame(24'h0000AA, 24'hFFFF55);
        drive_frame(24'h0000AA, 24'hFFFF55, 32);

        // Asynchronous reset in the middle of the right data bits.
        fork
            drive_frame(24'h111111, 24'h222222, 32);
            begin
                repeat (32 * 16 + 8 * 16) @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                check("arst_left",  {24'd0, data_left},   48'd0);
                check("arst_right", {24'd0, data_right},  48'd0);
                check("arst_valid", {47'd0, data_valid},  48'd0);
                check("arst_error", {47'd0, frame_error}, 48'd0);
                last_left  = '0;
                last_right = '0;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
            end
        join
        expect_frame(24'h5A5A5A, 24'hA5A5A5);
        drive_frame(24'h5A5A5A, 24'hA5A5A5, 32);

        for (int k = 0; k < 4; k++) drive_bit(1'b1, 1'b0);

        check("final_left",       {24'd0, data_left},  {24'd0, last_left});
        check("final_right",      {24'd0, data_right}, {24'd0, last_right});
        check("valid_count",      48'(valid_seen),     48'(exp_valids));
        check("error_count",      48'(err_seen),       48'(exp_errs));
        check("scoreboard_empty", 48'(sb_q.size()),    48'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/audio_deserializer.md
Name: audio_deserializer

Overview:
I2S receiver for the codec ADC path. It samples the codec bit clock, LR clock and ADC data in the i_clock domain and deserializes one left word and one right word per frame. It presents both words in parallel with a one-cycle valid strobe. It is the capture counterpart of the DAC-side serializer and shares its clocking and framing: left channel while LR is low, MSB one bit-clock after the LR edge.

Parameters:
DATA_WIDTH, 24, bits captured per channel; bits beyond DATA_WIDTH in a longer slot are ignored.
SYNC_STAGES, 2, synchronizer flops on each codec input; must be at least 2.

Ports:
i_clock  input  1  system clock; must be at least 8x the codec bit clock.
i_reset_n  input  1  asynchronous, active-low reset.
i_enable  input  1  when low, block idles and emits no data.
i_codec_bit_clock  input  1  I2S BCLK from codec, asynchronous.
i_codec_lr_clock  input  1  I2S LRCLK from codec, asynchronous; 0 = left, 1 = right.
i_codec_adc_data  input  1  I2S ADC serial data, MSB first, changes on BCLK falling edge.
o_data_left  output  DATA_WIDTH  last complete left sample, signed two's complement.
o_data_right  output  DATA_WIDTH  last complete right sample.
o_data_valid  output  1  one-cycle pulse when o_data_left and o_data_right update together.
o_frame_error  output  1  one-cycle pulse when an LR edge arrives before DATA_WIDTH bits are captured.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - all outputs 0; shift registers and bit counter 0; state IDLE.
  - synchronizer and edge-detect flops cleared.
- Input conditioning:
  - BCLK, LRCLK and ADC data each pass through SYNC_STAGES flops plus one delay flop.
  - bclk_rise, lr_rise and lr_fall are one-cycle pulses computed from the stable and delayed copies.
  - ADC data is sampled from the same pipeline stage as stable BCLK, so a bit is captured in the cycle bclk_rise is high.
- FSM states: IDLE, WAIT_LR_FALLING, LEFT_SKIP, LEFT_SHIFT, WAIT_LR_RISING, RIGHT_SKIP, RIGHT_SHIFT.
  - IDLE: counter cleared. Moves to WAIT_LR_FALLING when i_enable is 1.
  - WAIT_LR_FALLING: on lr_fall -> LEFT_SKIP. A frame always starts on the left channel; a mid-frame enable waits for the next left.
  - LEFT_SKIP: first bclk_rise after the edge is the I2S delay slot and is discarded -> LEFT_SHIFT.
  - LEFT_SHIFT: each bclk_rise does shift_left <= {shift_left[DATA_WIDTH-2:0], data} and counter+1. When the counter reaches DATA_WIDTH: copy to left hold register, clear counter -> WAIT_LR_RISING.
  - WAIT_LR_RISING: extra slot bits are ignored. On lr_rise -> RIGHT_SKIP.
  - RIGHT_SKIP and RIGHT_SHIFT: mirror the left states. On completion, in the next cycle:
    - o_data_left <= left hold register; o_data_right <= shift_right;
    - o_data_valid = 1 for exactly one cycle;
    - state -> WAIT_LR_FALLING.
- Latency: o_data_valid asserts one i_clock cycle after the bclk_rise that captures the right LSB.
- Outputs hold their value between valid pulses.
- Boundary conditions:
  - LR edge during LEFT_SKIP, LEFT_SHIFT, RIGHT_SKIP or RIGHT_SHIFT: o_frame_error pulses for 1 cycle, partial words are discarded, no valid is emitted.
    - lr_fall goes to LEFT_SKIP; lr_rise goes to WAIT_LR_FALLING.
  - bclk_rise coincident with an LR edge in a WAIT state: the edge takes priority, and that bclk_rise is not counted as the skip bit.
  - i_enable low in any state: next cycle -> IDLE. The counter is cleared, no valid and no error are raised, and the outputs keep their last values.
  - Reset asserted mid-word: everything clears immediately. After release, capture waits for a fresh lr_fall.
- Counter width is $clog2(DATA_WIDTH+1) and it never wraps.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_DATA_WIDTH = 24;
  - the I2S channel-state enum typedef (reused by the serializer);
  - the SYNC_STAGES default.
- One natural sub-module, i2s_edge_detect: parameterized synchronizer plus rise/fall pulse generator. It is instantiated for BCLK and LRCLK, with a plain sync-only path for data, and is reusable by the serializer.

Test Plan:
- Normal frame: BCLK = 1/16 of i_clock, 32-bit slots, left 24'h800001, right 24'h7FFFFE -> one o_data_valid pulse with those values, o_frame_error stays 0.
- Back-to-back frames: 4 frames, left 24'h000001 to 24'h000004, right the negated values -> exactly 4 valid pulses, in order, each 1 cycle wide.
- Short slot: LR toggles after 12 left bits -> o_frame_error pulses once, no valid for that frame, and the next full frame (24'h123456 / 24'hABCDEF) is received correctly.
- Start mid-frame: release reset while LR is high, mid right slot -> no valid until the first complete left+right pair after the next lr_fall.
- Enable drop: i_enable low during LEFT_SHIFT for 100 cycles, then high -> no valid or error, outputs unchanged, then a correct capture on the following frame.
- Async reset: assert i_reset_n low mid RIGHT_SHIFT -> all outputs 0 within the same cycle; after release, the next full frame (24'h5A5A5A / 24'hA5A5A5) is captured.
